fetch_sequencer: RTL and testbench

- Instruction-fetch sequencer directly upstream of the ROM -> ALU -> memory datapath.
- Generates the 7-bit ROM address `dir` and the issue-valid `en` that the datapath's first buffer stage samples.
- Walks a programmed address range from `start_addr` to `end_addr`, with stall and single-step support.
- Waits for the downstream pipeline to drain before signalling `done`, so the last memory write has landed when `done` pulses.

---
 rtl/fetch_sequencer_pkg.sv | 31 +++
 rtl/fetch_pc_counter.sv | 57 +++++
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer and the datapath it feeds.
// Holds the sequencer state encoding, the default address width and pipeline depth
// shared with the datapath top, and the bit positions of the instruction fields.
package fetch_sequencer_pkg;

    // Width of the ROM address bus `dir`.
    localparam int ADDR_W_DEF     = 7;
    // Register stages between an issue and its memory write (ROM buffer + ALU buffer).
    localparam int PIPE_DEPTH_DEF = 2;
    // Issued-instruction counter width; must hold 2^ADDR_W_DEF.
    localparam int CNT_W_DEF      = 8;

    // Instruction word layout as decoded by the downstream datapath.
    localparam int INSTR_W  = 32;
    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 25;
    localparam int SEL_MSB  = 24;
    localparam int SEL_LSB  = 22;
    localparam int A_MSB    = 21;
    localparam int A_LSB    = 11;
    localparam int B_MSB    = 10;
    localparam int B_LSB    = 0;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter for the fetch sequencer.
// Loadable, enable-gated counter that wraps modulo 2^ADDR_W, together with a
// captured end address and a registered flag that is high while pc equals it.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   load       - load pc with load_addr and capture load_end
//   load_addr  - value loaded into pc
//   load_end   - inclusive end address captured on load
//   inc        - advance pc by one (wrapping); ignored while load is high
//   pc         - current program counter
//   at_end     - high while pc equals the captured end address
module fetch_pc_counter #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] load_end,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              at_end
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] end_r;
    logic              at_end_r;
    logic [ADDR_W-1:0] pc_inc_s;

    // Natural overflow of the ADDR_W-bit sum gives the modulo-2^ADDR_W wrap.
    assign pc_inc_s = pc_r + ADDR_W'(1);

    // pc, end address and the precomputed end-match flag; the flag is
    // evaluated against the next pc so it is valid in the same cycle as pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= '0;
            end_r    <= '0;
            at_end_r <= 1'b0;
        end else if (load) begin
            pc_r     <= load_addr;
            end_r    <= load_end;
            at_end_r <= (load_addr == load_end);
        end else if (inc) begin
            pc_r     <= pc_inc_s;
            at_end_r <= (pc_inc_s == end_r);
        end else begin
            pc_r     <= pc_r;
            end_r    <= end_r;
            at_end_r <= at_end_r;
        end
    end

    assign pc     = pc_r;
    assign at_end = at_end_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer feeding the ROM -> ALU -> memory datapath.
// Issues ROM addresses from start_addr to end_addr (inclusive, wrapping),
// honours stall and single-step, then waits PIPE_DEPTH cycles for the last
// write to land before pulsing done.
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   start       - begin a run (only looked at in IDLE)
//   start_addr  - first address, captured on start
//   end_addr    - last address (inclusive), captured on start
//   step_mode   - issue only on step pulses, captured on start
//   step        - single-step request (one issue per high cycle)
//   stall       - suppress issue this cycle
//   dir         - registered ROM address
//   en          - registered issue valid for dir
//   busy        - high in RUN and DRAIN
//   done        - one-cycle pulse at the end of DRAIN
//   count       - instructions issued in the current or last run
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              step_mode,
    input  logic              step,
    input  logic              stall,
    output logic [ADDR_W-1:0] dir,
    output logic              en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;

    logic [ADDR_W-1:0]  dir_r;
    logic [ADDR_W-1:0]  dir_nxt_s;
    logic               en_r;
    logic               en_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               done_r;
    logic               done_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [DRAIN_W-1:0] drain_r;
    logic [DRAIN_W-1:0] drain_nxt_s;
    logic               step_mode_r;
    logic               step_mode_nxt_s;

    logic               pc_load_s;
    logic               pc_inc_s;
    logic [ADDR_W-1:0]  pc_s;
    logic               at_end_s;
    logic               issue_s;

    fetch_pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load_s),
        .load_addr (start_addr),
        .load_end  (end_addr),
        .inc       (pc_inc_s),
        .pc        (pc_s),
        .at_end    (at_end_s)
    );

    // In free-run mode step is ignored; in step mode every high step cycle issues.
    assign issue_s = !stall && (!step_mode_r || step);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt_s     = state_r;
        dir_nxt_s       = dir_r;
        en_nxt_s        = 1'b0;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        count_nxt_s     = count_r;
        drain_nxt_s     = drain_r;
        step_mode_nxt_s = step_mode_r;
        pc_load_s       = 1'b0;
        pc_inc_s        = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s     = RUN;
                    busy_nxt_s      = 1'b1;
                    count_nxt_s     = '0;
                    step_mode_nxt_s = step_mode;
                    pc_load_s       = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    dir_nxt_s   = pc_s;
                    en_nxt_s    = 1'b1;
                    count_nxt_s = count_r + CNT_W'(1);
                    if (at_end_s) begin
                        state_nxt_s = DRAIN;
                        drain_nxt_s = DRAIN_W'(PIPE_DEPTH);
                    end else begin
                        pc_inc_s = 1'b1;
                    end
                end else begin
                    en_nxt_s = 1'b0;
                end
            end
            DRAIN: begin
                // The last issue's write lands PIPE_DEPTH edges after it left;
                // done is raised on that edge and busy drops with it.
                if (drain_r <= DRAIN_W'(1)) begin
                    state_nxt_s = IDLE;
                    drain_nxt_s = '0;
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                end else begin
                    drain_nxt_s = drain_r - DRAIN_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
                drain_nxt_s = '0;
            end
        endcase
    end

    // Registered outputs and run context.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_r       <= '0;
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            count_r     <= '0;
            drain_r     <= '0;
            step_mode_r <= 1'b0;
        end else begin
            dir_r       <= dir_nxt_s;
            en_r        <= en_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            count_r     <= count_nxt_s;
            drain_r     <= drain_nxt_s;
            step_mode_r <= step_mode_nxt_s;
        end
    end

    assign dir   = dir_r;
    assign en    = en_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign count = count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer. The driver applies directed and
// random runs; for every edge it works out from the run rules whether an
// instruction issues and which address it carries, and queues the expected
// (cycle, address) and (cycle, count) events. The monitor compares the DUT
// outputs against those queues on every falling edge.
module tb_fetch_sequencer;

    localparam int ADDR_W     = 7;
    localparam int PIPE_DEPTH = 2;
    localparam int CNT_W      = 8;
    localparam int NADDR      = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              step_mode;
    logic              step;
    logic              stall;
    logic [ADDR_W-1:0] dir;
    logic              en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;

    fetch_sequencer #(
        .ADDR_W     (ADDR_W),
        .PIPE_DEPTH (PIPE_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .step_mode  (step_mode),
        .step       (step),
        .stall      (stall),
        .dir        (dir),
        .en         (en),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    typedef struct {
        int cyc;
        int addr;
    } iss_t;

    typedef struct {
        int cyc;
        int cnt;
    } done_t;

    iss_t  exp_iss_q[$];
    done_t exp_done_q[$];

    int n_vec;
    int n_err;
    int cyc;
    bit mon_on;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares en/dir and done/count with the scoreboard every cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            iss_t  ei;
            done_t ed;
            bit    exp_en;
            bit    exp_done;
            while (exp_iss_q.size() > 0 && exp_iss_q[0].cyc < cyc) begin
                void'(exp_iss_q.pop_front());
            end
            while (exp_done_q.size() > 0 && exp_done_q[0].cyc < cyc) begin
                void'(exp_done_q.pop_front());
            end
            exp_en   = (exp_iss_q.size() > 0) && (exp_iss_q[0].cyc == cyc);
            exp_done = (exp_done_q.size() > 0) && (exp_done_q[0].cyc == cyc);
            chk("en", en, exp_en);
            if (exp_en) begin
                ei = exp_iss_q.pop_front();
                chk("dir", dir, ei.addr);
            end
            if (en) begin
                chk("busy_on_issue", busy, 1);
            end
            chk("done", done, exp_done);
            if (exp_done) begin
                ed = exp_done_q.pop_front();
                chk("count_at_done", count, ed.cnt);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_dir"},   dir,   0);
        chk({tag, "_en"},    en,    0);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_done"},  done,  0);
        chk({tag, "_count"}, count, 0);
    endtask

    // One run. Inputs are driven 1 time unit after a rising edge and take
    // effect on the next edge, so an issue decided now is visible at cyc+1.
    task automatic run_one(input int sa, input int ea, input bit sm, input int stall_pct,
                           input int step_gap, input int stall_issue, input int rst_at,
                           input bit junk);
        int n;
        int issued;
        int i;
        int done_cyc;
        bit stalled_once;
        bit cond;
        n = ((ea - sa + NADDR) % NADDR) + 1;
        start      = 1'b1;
        start_addr = ADDR_W'(sa);
        end_addr   = ADDR_W'(ea);
        step_mode  = sm;
        stall      = 1'($urandom_range(1));
        step       = 1'($urandom_range(1));
        @(posedge clk); #1;
        issued = 0;
        i = 0;
        stalled_once = 1'b0;
        done_cyc = cyc;
        while (issued < n && i < 4000) begin
            if (i == rst_at) begin
                rst   = 1'b1;
                start = 1'b0;
                exp_done_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_reset_values("midrun_reset");
                repeat (3) begin
                    @(posedge clk); #1;
                end
                return;
            end
            if (junk) begin
                start      = 1'($urandom_range(1));
                start_addr = ADDR_W'($urandom);
                end_addr   = ADDR_W'($urandom);
                step_mode  = 1'($urandom_range(1));
            end else begin
                start = 1'b0;
            end
            if (stall_issue == issued && !stalled_once) begin
                stall = 1'b1;
                stalled_once = 1'b1;
            end else begin
                stall = ($urandom_range(99) < stall_pct);
            end
            if (step_gap > 0) begin
                step = (i % step_gap == 0);
            end else begin
                step = 1'($urandom_range(1));
            end
            cond = !stall && (!sm || step);
            if (cond) begin
                exp_iss_q.push_back('{cyc + 1, (sa + issued) % NADDR});
                issued++;
                if (issued == n) begin
                    done_cyc = cyc + 1 + PIPE_DEPTH;
                    exp_done_q.push_back('{done_cyc, n});
                end
            end
            @(posedge clk); #1;
            i++;
        end
        start = 1'b0;
        while (cyc < done_cyc) begin
            stall = 1'($urandom_range(1));
            step  = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        mon_on     = 1'b0;
        rst        = 1'b1;
        start      = 1'b1;
        start_addr = 7'd5;
        end_addr   = 7'd9;
        step_mode  = 1'b0;
        step       = 1'b0;
        stall      = 1'b0;
        // start held together with rst: no run may begin
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_reset_values("reset");
        mon_on = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("idle_after_reset_busy", busy, 0);

        // Directed runs from the test plan.
        run_one(0, 3, 1'b0, 0, 0, -1, -1, 1'b0);
        run_one(5, 7, 1'b0, 0, 0, 1, -1, 1'b0);
        run_one(10, 11, 1'b1, 0, 3, -1, -1, 1'b0);
        run_one(126, 1, 1'b0, 0, 0, -1, -1, 1'b0);
        run_one(0, 9, 1'b0, 0, 0, -1, 2, 1'b0);
        run_one(20, 27, 1'b0, 0, 0, -1, -1, 1'b1);
        run_one(42, 42, 1'b0, 0, 0, -1, -1, 1'b0);
        run_one(64, 63, 1'b0, 0, 0, -1, -1, 1'b0);
        // count holds in IDLE until the next start
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("count_hold_idle", count, 128);

        // Randomized runs with stall, step and occasional mid-run reset.
        for (int r = 0; r < 24; r++) begin
            int sa;
            int ea;
            int kind;
            sa   = $urandom_range(127);
            kind = $urandom_range(3);
            case (kind)
                0: ea = $urandom_range(127);
                1: ea = sa;
                2: ea = (sa + 127) % NADDR;
                default: begin
                    sa = $urandom_range(127, 120);
                    ea = $urandom_range(5);
                end
            endcase
            run_one(sa, ea, ($urandom_range(3) == 0), $urandom_range(40), 0, -1,
                    ($urandom_range(7) == 0) ? $urandom_range(4) : -1, 1'b1);
        end

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pending_issues", exp_iss_q.size(), 0);
        chk("pending_done", exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
